ps2_key_decoder: RTL
====================

# ps2_key_decoder

Receives raw PS/2 keyboard clock/data, frames 11-bit serial words, validates start/parity/stop, and assembles make/break/extended scan-code sequences into single-cycle key events on the system clock. Sits directly upstream of the game controller. It replaces free-running PS2Clk-domain shifting with a fully synchronous front end and emits one-cycle, CLK-domain action pulses (start, up, down, left, right, esc, pause, resume) on key release.

## Interface
- FILTER_LEN, 8: consecutive identical CLK samples required before the synchronized PS2Clk level is accepted.
- TIMEOUT_CYCLES, 100000: CLK cycles without an accepted PS2Clk falling edge before a partial frame is discarded.

- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- PS2Clk  in  1  raw keyboard clock, asynchronous.
- si  in  1  raw keyboard data, asynchronous.
- key_code  out  8  last decoded scan code; held until next event.
- key_valid  out  1  one-cycle pulse: new key event on key_code.
- key_release  out  1  qualifies key_valid: event was preceded by F0.
- key_extended  out  1  qualifies key_valid: event was preceded by E0.
- frame_err  out  1  one-cycle pulse: bad start bit, bad stop bit, or timeout.
- parity_err  out  1  one-cycle pulse: parity failure (see Configuration).
- act_start, act_up, act_down, act_left, act_right, act_esc, act_pause, act_resume  out  1 each  one-cycle pulses on release of 1B, 75, 72, 6B, 74, 76, 4D, 2D respectively; E0 prefix ignored for matching.

## Operation
- Synchronizer: PS2Clk and si each through 2 flops. Filter: counter of identical synchronized PS2Clk samples, saturating at FILTER_LEN; filtered level updates only when count reaches FILTER_LEN. Accepted falling edge = filtered level 1→0.
- Framer: bit counter 0..10, shift register 11 bits, LSB first. Data sampled (synchronized si) on each accepted falling edge. Bit 0 start (must be 0), bits 1-8 data, bit 9 odd parity, bit 10 stop (must be 1).
- On bit 10: start≠0 or stop≠1 → frame_err, byte discarded; parity fail → per Configuration; else byte delivered to assembler. Bit counter returns to 0 in all cases.
- Watchdog: counter cleared on each accepted edge; when bit counter ≠0 and counter reaches TIMEOUT_CYCLES → bit counter to 0, frame_err pulse. Watchdog idle when bit counter =0.
- Assembler FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: E0→EXT; F0→BRK; other→emit (rel=0, ext=0).
  - EXT: F0→EXT_BRK; E0→EXT; other→emit (rel=0, ext=1), →IDLE.
  - BRK: E0→EXT_BRK; F0→BRK; other→emit (rel=1, ext=0), →IDLE.
  - EXT_BRK: E0/F0→stay; other→emit (rel=1, ext=1), →IDLE.
  - Emit: key_code←byte, key_release/key_extended←flags, key_valid pulse; if rel=1 and code matches table, corresponding act_* pulse in same cycle. Make codes produce key_valid only.
- frame_err or parity_err does not reset assembler state.

## Timing
- Reset value of every output 0; FSM IDLE; counters 0; filtered level 1.
- PS2Clk pin edge to accepted edge: 2 + FILTER_LEN CLK cycles (±1).
- key_valid, act_*, frame_err, parity_err asserted exactly 1 CLK after the cycle the stop-bit edge is accepted; width exactly 1 cycle.
- key_code/key_release/key_extended change only in the key_valid cycle.
- At most one event per frame; edges closer than 1 CLK after filtering cannot occur.
- RST mid-frame: partial frame and prefix flags dropped; next complete frame decodes normally. RST asserted in an output pulse cycle clears the pulse next cycle.
- Timeout and accepted edge in same cycle: edge wins, counter cleared.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity checked; failing frame discarded, parity_err pulses, no assembler input.
- Undefined: parity bit ignored; parity_err tied 0; all framed bytes with valid start/stop delivered.

## Test plan
- Reset, then frame 0x1C (parity 0) at 12.5 kHz PS2Clk -> key_valid once, key_code=1C, key_release=0, no act_*.
- Frames F0, 75 -> key_valid, key_code=75, key_release=1, key_extended=0, act_up single pulse coincident.
- Frames E0, F0, 6B -> key_valid, key_code=6B, release=1, extended=1, act_left pulse.
- Frame 0x1B with parity bit flipped, macro defined -> parity_err pulse, no key_valid; macro undefined -> key_valid, key_code=1B.
- 5 bits of a frame then silence > TIMEOUT_CYCLES -> frame_err pulse; following F0, 76 -> act_esc pulse.
- Glitch on PS2Clk shorter than FILTER_LEN cycles mid-frame -> ignored; frame 0x4D after F0 -> act_pause; RST during second of three frames -> no event from that frame, third decodes correctly.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw keyboard lines, frames 11-bit words,
// and turns make/break/extended sequences into one-cycle key events and game action pulses.
// Optional feature: define PS2_PARITY_CHECK_EN to check odd parity and drop frames that fail it.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2Clk,
    input  logic       si,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_extended,
    output logic       frame_err,
    output logic       parity_err,
    output logic       act_start,
    output logic       act_up,
    output logic       act_down,
    output logic       act_left,
    output logic       act_right,
    output logic       act_esc,
    output logic       act_pause,
    output logic       act_resume
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} asm_state_t;

    logic          clk_s1, clk_s2, si_s1, si_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall_edge;

    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] wd_cnt;
    logic          stop_edge, start_ok, stop_ok, par_ok, timeout, byte_valid;
    logic [7:0]    rx_byte;

    asm_state_t    state;
    logic          emit_rel, emit_ext;

    // Sync flops idle high so leaving reset never looks like a clock falling edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            si_s1    <= 1'b1;
            si_s2    <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= PS2Clk;
            clk_s2 <= clk_s1;
            si_s1  <= si;
            si_s2  <= si_s1;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign fall_edge  = clk_filt && !clk_s2 && (filt_cnt == FW'(FILTER_LEN - 1));
    assign stop_edge  = fall_edge && (bit_cnt == 4'd10);
    assign start_ok   = !shreg[0];
    assign stop_ok    = si_s2;
    assign par_ok     = ^shreg[9:1];
    assign rx_byte    = shreg[8:1];
    assign byte_valid = stop_edge && start_ok && stop_ok && (par_ok || !PARITY_EN);
    assign timeout    = (bit_cnt != 4'd0) && !fall_edge && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Framer and watchdog; the shift register fills from the top so the start bit lands in bit 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt    <= 4'd0;
            shreg      <= '0;
            wd_cnt     <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (fall_edge) begin
                wd_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= 4'd0;
                    frame_err  <= !start_ok || !stop_ok;
                    parity_err <= PARITY_EN && start_ok && stop_ok && !par_ok;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {si_s2, shreg[9:1]};
                end
            end else if (timeout) begin
                bit_cnt   <= 4'd0;
                wd_cnt    <= '0;
                frame_err <= 1'b1;
            end else if (bit_cnt != 4'd0) begin
                wd_cnt <= wd_cnt + TW'(1);
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign emit_rel = (state == BRK) || (state == EXT_BRK);
    assign emit_ext = (state == EXT) || (state == EXT_BRK);

    // Prefix bytes only move the state; any other byte is emitted with the flags gathered so far.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            key_code     <= 8'h00;
            key_valid    <= 1'b0;
            key_release  <= 1'b0;
            key_extended <= 1'b0;
            act_start    <= 1'b0;
            act_up       <= 1'b0;
            act_down     <= 1'b0;
            act_left     <= 1'b0;
            act_right    <= 1'b0;
            act_esc      <= 1'b0;
            act_pause    <= 1'b0;
            act_resume   <= 1'b0;
        end else begin
            key_valid  <= 1'b0;
            act_start  <= 1'b0;
            act_up     <= 1'b0;
            act_down   <= 1'b0;
            act_left   <= 1'b0;
            act_right  <= 1'b0;
            act_esc    <= 1'b0;
            act_pause  <= 1'b0;
            act_resume <= 1'b0;
            if (byte_valid) begin
                if (rx_byte == 8'hE0) begin
                    case (state)
                        BRK, EXT_BRK: state <= EXT_BRK;
                        default:      state <= EXT;
                    endcase
                end else if (rx_byte == 8'hF0) begin
                    case (state)
                        EXT, EXT_BRK: state <= EXT_BRK;
                        default:      state <= BRK;
                    endcase
                end else begin
                    state        <= IDLE;
                    key_code     <= rx_byte;
                    key_release  <= emit_rel;
                    key_extended <= emit_ext;
                    key_valid    <= 1'b1;
                    act_start    <= emit_rel && (rx_byte == 8'h1B);
                    act_up       <= emit_rel && (rx_byte == 8'h75);
                    act_down     <= emit_rel && (rx_byte == 8'h72);
                    act_left     <= emit_rel && (rx_byte == 8'h6B);
                    act_right    <= emit_rel && (rx_byte == 8'h74);
                    act_esc      <= emit_rel && (rx_byte == 8'h76);
                    act_pause    <= emit_rel && (rx_byte == 8'h4D);
                    act_resume   <= emit_rel && (rx_byte == 8'h2D);
                end
            end
        end
    end

endmodule
